// File: rtl/seqgen_pkg.sv
// Shared constants and state encoding for the serial pattern transmitter.
package seqgen_pkg;

  localparam int unsigned STAT_W = 3;

  localparam logic [STAT_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STAT_W-1:0] ST_SHIFT = 3'd1;
  localparam logic [STAT_W-1:0] ST_GAP   = 3'd2;
  localparam logic [STAT_W-1:0] ST_DONE  = 3'd3;

  localparam int unsigned PAT_W_DEF   = 8;
  localparam int unsigned CNT_W_DEF   = 4;
  localparam int unsigned GAP_CYC_DEF = 2;

  typedef enum logic [STAT_W-1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StGap   = ST_GAP,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/seqgen_shreg.sv
// Loadable PISO shift register plus a held copy of the pattern for frame reloads.
// The working register is loaded already shifted by one: the MSB goes straight
// to the output register at load time, so msb always offers the *next* bit.
module seqgen_shreg #(
  parameter int unsigned PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             reload,
  input  logic [PAT_W-1:0] din,
  output logic             msb,
  output logic             head
);

  logic [PAT_W-1:0] sr;
  logic [PAT_W-1:0] copy;

  // Capture / reload / shift of the pattern bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      copy <= '0;
    end else if (load) begin
      copy <= din;
      sr   <= din << 1;
    end else if (reload) begin
      sr <= copy << 1;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb  = sr[PAT_W-1];
  assign head = copy[PAT_W-1];

endmodule

// File: rtl/seqgen.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first, repeated
// a programmed number of times with an optional idle gap between frames.
module seqgen
  import seqgen_pkg::*;
#(
  parameter int unsigned PAT_W   = PAT_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  input  logic [CNT_W-1:0]  repeat_n,
  output logic              out,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [STAT_W-1:0] statout
);

  localparam int unsigned BW = $clog2(PAT_W);
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  state_e           state;
  logic [CNT_W-1:0] frame_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  logic sr_load, sr_shift, sr_reload, sr_msb, sr_head;
  logic last_frame;

  assign last_frame = (frame_cnt == CNT_W'(1));

  seqgen_shreg #(
    .PAT_W (PAT_W)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load   (sr_load),
    .shift  (sr_shift),
    .reload (sr_reload),
    .din    (pattern),
    .msb    (sr_msb),
    .head   (sr_head)
  );

  // Shift-register controls decoded from the current state.
  always_comb begin
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_reload = 1'b0;
    case (state)
      StIdle:  sr_load = start && (repeat_n != '0);
      StShift: begin
        if (bit_cnt != BIT_LAST) begin
          sr_shift = 1'b1;
        end else if (!last_frame && (GAP_CYC == 0)) begin
          sr_reload = 1'b1;
        end
      end
      StGap:   sr_reload = (gap_cnt == GAP_LAST);
      default: ;
    endcase
  end

  // Main FSM with registered outputs and frame/bit/gap counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      out       <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (repeat_n != '0) begin
              state     <= StShift;
              frame_cnt <= repeat_n;
              bit_cnt   <= '0;
              out       <= pattern[PAT_W-1];
              valid     <= 1'b1;
            end else begin
              state <= StDone;
              done  <= 1'b1;
            end
          end
        end
        StShift: begin
          if (bit_cnt != BIT_LAST) begin
            bit_cnt <= bit_cnt + 1'b1;
            out     <= sr_msb;
          end else begin
            // LSB has been on the line for a cycle: this frame is complete.
            frame_cnt <= frame_cnt - 1'b1;
            bit_cnt   <= '0;
            if (last_frame) begin
              state <= StDone;
              out   <= 1'b0;
              valid <= 1'b0;
              done  <= 1'b1;
            end else if (GAP_CYC > 0) begin
              state   <= StGap;
              out     <= 1'b0;
              valid   <= 1'b0;
              gap_cnt <= '0;
            end else begin
              out <= sr_head;
            end
          end
        end
        StGap: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= StShift;
            out     <= sr_head;
            valid   <= 1'b1;
            bit_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          // Unused codes recover to IDLE.
          state <= StIdle;
          out   <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign statout = state;

endmodule

// File: tb/tb_seqgen.sv
// Self-checking bench for seqgen: scoreboard of expected serial bits, per-cycle
// state/output invariants, and per-request busy/done accounting.
module tb_seqgen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // DUT A: GAP_CYC = 2
  logic       start_a = 1'b0;
  logic [7:0] pattern_a = '0;
  logic [3:0] repeat_a = '0;
  logic       out_a, valid_a, busy_a, done_a;
  logic [2:0] statout_a;

  // DUT B: GAP_CYC = 0 (loopback)
  logic       start_b = 1'b0;
  logic [7:0] pattern_b = '0;
  logic [3:0] repeat_b = '0;
  logic       out_b, valid_b, busy_b, done_b;
  logic [2:0] statout_b;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_tot_a = 0, done_tot_a = 0;
  int busy_tot_b = 0, done_tot_b = 0;
  int hits = 0;
  logic [3:0] win = '0;
  logic qa[$];
  logic qb[$];

  always #5 clk = ~clk;

  seqgen #(.PAT_W(8), .CNT_W(4), .GAP_CYC(2)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start_a),
    .pattern  (pattern_a),
    .repeat_n (repeat_a),
    .out      (out_a),
    .valid    (valid_a),
    .busy     (busy_a),
    .done     (done_a),
    .statout  (statout_a)
  );

  seqgen #(.PAT_W(8), .CNT_W(4), .GAP_CYC(0)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start_b),
    .pattern  (pattern_b),
    .repeat_n (repeat_b),
    .out      (out_b),
    .valid    (valid_b),
    .busy     (busy_b),
    .done     (done_b),
    .statout  (statout_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and check every observable of both DUTs.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (valid_a) begin
        if (qa.size() == 0) check("a_extra_bit", valid_a, 0);
        else check("a_bit", out_a, qa.pop_front());
        check("a_st_shift", statout_a, 1);
      end else begin
        check("a_out_quiet", out_a, 0);
      end
      if (done_a) check("a_st_done", statout_a, 3);
      if (!busy_a) check("a_st_idle", statout_a, 0);
      else if (!valid_a && !done_a) check("a_st_gap", statout_a, 2);
      if (busy_a) busy_tot_a++;
      if (done_a) done_tot_a++;

      if (valid_b) begin
        if (qb.size() == 0) check("b_extra_bit", valid_b, 0);
        else check("b_bit", out_b, qb.pop_front());
        check("b_st_shift", statout_b, 1);
        win = {win[2:0], out_b};
        if (win == 4'b1011) hits++;
      end else begin
        check("b_out_quiet", out_b, 0);
      end
      if (done_b) check("b_st_done", statout_b, 3);
      if (!busy_b) check("b_st_idle", statout_b, 0);
      else if (!done_b) check("b_no_gap", valid_b, 1);
      if (busy_b) busy_tot_b++;
      if (done_b) done_tot_b++;
    end
  endtask

  function automatic int cur_done(input int sel);
    return (sel == 0) ? done_tot_a : done_tot_b;
  endfunction

  // Issue one request, push its expected bits, and check busy/done totals.
  task automatic send_req(input int sel, input logic [7:0] pat, input logic [3:0] rep,
                          input bit poke);
    int gap, r, exp_busy, b0, d0, k;
    gap = (sel == 0) ? 2 : 0;
    r = int'(rep);
    exp_busy = (r == 0) ? 1 : r * 8 + (r - 1) * gap + 1;
    for (int f = 0; f < r; f++) begin
      for (int i = 7; i >= 0; i--) begin
        if (sel == 0) qa.push_back(pat[i]);
        else qb.push_back(pat[i]);
      end
    end
    if (sel == 0) begin
      b0 = busy_tot_a; d0 = done_tot_a;
      pattern_a = pat; repeat_a = rep; start_a = 1'b1;
    end else begin
      b0 = busy_tot_b; d0 = done_tot_b;
      pattern_b = pat; repeat_b = rep; start_b = 1'b1;
    end
    tick();
    // Scramble inputs after acceptance; the request in flight must not notice.
    if (sel == 0) begin
      start_a = 1'b0; pattern_a = ~pat; repeat_a = rep + 4'd1;
      check("lat_valid_a", valid_a, r != 0);
      check("lat_done_a", done_a, r == 0);
    end else begin
      start_b = 1'b0; pattern_b = ~pat; repeat_b = rep + 4'd1;
      check("lat_valid_b", valid_b, r != 0);
      check("lat_done_b", done_b, r == 0);
    end
    if (poke && sel == 0) begin
      tick();
      tick();
      start_a = 1'b1; pattern_a = 8'hFF;
      tick();
      start_a = 1'b0;
    end
    k = 0;
    while (cur_done(sel) == d0 && k < 400) begin
      tick();
      k++;
    end
    repeat (3) tick();
    if (sel == 0) begin
      check("req_done_cnt_a", done_tot_a - d0, 1);
      check("req_busy_cyc_a", busy_tot_a - b0, exp_busy);
      check("req_bits_left_a", qa.size(), 0);
    end else begin
      check("req_done_cnt_b", done_tot_b - d0, 1);
      check("req_busy_cyc_b", busy_tot_b - b0, exp_busy);
      check("req_bits_left_b", qb.size(), 0);
    end
  endtask

  initial begin
    int d0;
    @(posedge clk);
    #1;
    check("rst_out", out_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_stat", statout_a, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Basic send
    send_req(0, 8'b0010_1011, 4'd1, 1'b0);
    // Repeats with gap: 3*8 + 2*2 + 1 = 29 busy cycles
    send_req(0, 8'hA5, 4'd3, 1'b0);
    // Zero repeats
    send_req(0, 8'h5A, 4'd0, 1'b0);
    // Ignored start and input isolation
    send_req(0, 8'h3C, 4'd1, 1'b1);

    // Reset mid-frame during bit 4 of 8'h3C
    d0 = done_tot_a;
    for (int i = 7; i >= 0; i--) qa.push_back(1'((8'h3C >> i) & 1));
    pattern_a = 8'h3C; repeat_a = 4'd1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (3) tick();
    check("pre_rst_out", out_a, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out", out_a, 0);
    check("arst_valid", valid_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_done", done_a, 0);
    check("arst_stat", statout_a, 0);
    qa.delete();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_nodone", done_tot_a - d0, 0);
    check("post_rst_idle", busy_a, 0);
    send_req(0, 8'h3C, 4'd1, 1'b0);

    // Loopback, no gap: 1011_0101 twice holds three 1011 occurrences,
    // one spanning the frame boundary.
    win = '0;
    hits = 0;
    send_req(1, 8'b1011_0101, 4'd2, 1'b0);
    check("loop_hits", hits, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seqgen.md
Name: seqgen

Overview:
- Serial bit-pattern transmitter: the sending end of the serial sequence-detector interface.
- Loads a parallel pattern and shifts it out MSB-first on a one-bit line, one bit per clock.
- Repeats the pattern a programmed number of times, with an optional idle gap between frames.
- Drives `seqcheck.in` directly in the FSM lab design and exposes its state code on `statout`, in the same style as the detector.

Parameters:
- PAT_W, 8: pattern length in bits; legal range 2 to 32.
- CNT_W, 4: width of the repeat count.
- GAP_CYC, 2: idle cycles inserted between repeated frames; 0 gives back-to-back frames.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to transmit; sampled only in IDLE.
- pattern  in  PAT_W  pattern to send; captured on an accepted start.
- repeat_n  in  CNT_W  number of frames to send; captured on an accepted start.
- out  out  1  serial data, MSB of the pattern first.
- valid  out  1  high on every cycle in which `out` carries a pattern bit.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a request completes.
- statout  out  3  current state code.

Behaviour:
- Reset: while rst is high, asynchronously force state IDLE and out=0, valid=0, busy=0, done=0, statout=3'd0. Clear all internal registers. Reset asserted mid-frame aborts the frame: no done pulse, and no frame is resumed after release.
- State codes: IDLE=0, SHIFT=1, GAP=2, DONE=3. Codes 4 to 7 are unused; if reached, return to IDLE on the next edge.
- All outputs are registered; no combinational path from any input to any output.
- IDLE:
  - start=1 at an edge with repeat_n≠0 → capture pattern into the shift register and repeat_n into the frame counter.
  - At that same edge set state=SHIFT, out=pattern[PAT_W-1], valid=1.
  - The first bit is therefore visible in the cycle immediately after the accepting edge (latency 1).
- Zero repeats: start=1 with repeat_n=0 → go straight to DONE; valid is never asserted.
- SHIFT:
  - Each edge shifts left by one and presents the next bit, so bit i of the frame appears PAT_W-1-i cycles after the MSB.
  - After the LSB has been presented for one cycle, decrement the frame counter.
  - Counter still nonzero and GAP_CYC>0 → GAP, with out=0 and valid=0.
  - Counter still nonzero and GAP_CYC=0 → reload the captured pattern and continue SHIFT with no bubble.
  - Counter zero → DONE.
- GAP: hold for exactly GAP_CYC cycles with out=0 and valid=0, then reload the captured pattern and re-enter SHIFT with its MSB.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start in DONE or any busy state is ignored. Changes to pattern or repeat_n after acceptance do not affect the request in flight.
- Back-to-back requests: start may be held high continuously. A new request is accepted in the first IDLE cycle, so consecutive requests are separated by one IDLE cycle.
- Total busy cycles for repeat_n=R≥1: R·PAT_W + (R-1)·GAP_CYC + 1.

Decomposition:
- `seqgen_pkg` holds:
  - state encodings as localparams ST_IDLE/ST_SHIFT/ST_GAP/ST_DONE;
  - STAT_W=3;
  - the default PAT_W, CNT_W and GAP_CYC values.
- One natural sub-module, `seqgen_shreg`:
  - loadable PISO shift register, PAT_W wide;
  - inputs clk, rst, load, shift, din;
  - output msb;
  - also holds the captured pattern copy used for reload on repeats.
- FSM, frame counter and gap counter stay in the top level.

Test Plan:
- Basic send: pattern=8'b0010_1011, repeat_n=1, start pulsed 1 cycle → out = 0,0,1,0,1,0,1,1 on 8 consecutive cycles with valid=1; done=1 on cycle 9; busy for 9 cycles; statout sequence 1×8, then 3, then 0.
- Repeats with gap: pattern=8'hA5, repeat_n=3, GAP_CYC=2 → three A5 frames separated by 2 cycles of valid=0/out=0. busy lasts 3·8+2·2+1 = 29 cycles; a single done pulse.
- Zero repeats: repeat_n=0 → statout goes 0→3→0; done pulses one cycle after start; valid never 1.
- Ignored start and input isolation: start re-pulsed and pattern changed to 8'hFF during frame 1 of 8'h3C → the transmitted bits remain 8'h3C; no extra frame is sent.
- Reset mid-frame: rst=1 during bit 4 → out, valid, busy, done and statout all go 0 immediately, without waiting for a clock edge. After release, IDLE with no done pulse; the next start sends a clean frame.
- Loopback: out→seqcheck.in with GAP_CYC=0 and a pattern containing the detector's target sequence, repeated 2 times → the detector's out asserts once per occurrence, including occurrences spanning the frame boundary.
